// File: rtl/bist_pkg.sv
// Shared types, constants and golden arithmetic for the equation-datapath BIST sequencer.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        APPLY = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } bist_state_e;

    localparam int unsigned LFSR_W = 40;
    // Fibonacci taps 40,38,21,19 expressed as a mask over q[39:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 40'hA000140000;
    localparam logic [15:0] FAIL_NONE = 16'hFFFF;

    function automatic logic [15:0] golden_a(input logic [7:0] x1, input logic [7:0] x2);
        return (16'(x1) * 16'd3) + (16'(x2) * 16'd5);
    endfunction

    function automatic logic [15:0] golden_b(input logic [7:0] v, input logic [7:0] t,
                                             input logic [7:0] c);
        return (16'(v) * 16'(t)) + 16'(c);
    endfunction

endpackage

// File: rtl/bist_lfsr40.sv
// 40-bit Fibonacci LFSR operand source; reloads seed on reset or load, advances on step.
module bist_lfsr40
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic fb_s;

    assign fb_s = ^(q & LFSR_TAPS);

    // Shift register: load has priority over step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[LFSR_W-2:0], fb_s};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer for the equation datapath: drives LFSR operand sets, checks results, reports pass/fail.
// Optional build macro BIST_EARLY_ABORT_EN ends a run on the first mismatching vector.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned       NUM_VECTORS = 64,
    parameter int unsigned       DUT_LATENCY = 1,
    parameter logic [LFSR_W-1:0] SEED        = 40'hA55AC33C96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic [15:0] first_fail_idx,
    output logic [7:0]  x1,
    output logic [7:0]  x2,
    output logic [7:0]  v,
    output logic [7:0]  t,
    output logic [7:0]  c,
    output logic        equation_flag,
    input  logic [15:0] dut_a,
    input  logic [15:0] dut_b
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 40'h0) ? 40'h1 : SEED;
    localparam logic [15:0]       LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]        LAT_LOAD = 4'(DUT_LATENCY);

    bist_state_e       state_r;
    bist_state_e       state_nxt_s;
    logic [LFSR_W-1:0] lfsr_q_s;
    logic              lfsr_load_s;
    logic              lfsr_step_s;
    logic [15:0]       vec_idx_r;
    logic [3:0]        wait_cnt_r;
    logic [15:0]       gold_a_s;
    logic [15:0]       gold_b_s;
    logic [15:0]       fail_cnt_nxt_s;
    logic              mismatch_s;
    logic              last_vec_s;

    assign lfsr_load_s = (state_r == LOAD);
    assign lfsr_step_s = (state_r == CHECK);
    assign gold_a_s    = golden_a(x1, x2);
    assign gold_b_s    = golden_b(v, t, c);
    assign mismatch_s  = (dut_a != gold_a_s) || (dut_b != gold_b_s);
    assign last_vec_s  = (vec_idx_r == LAST_IDX);

    bist_lfsr40 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .seed  (SEED_EFF),
        .step  (lfsr_step_s),
        .q     (lfsr_q_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = LOAD;
                else       state_nxt_s = IDLE;
            end
            LOAD:  state_nxt_s = APPLY;
            APPLY: state_nxt_s = WAIT;
            WAIT: begin
                // <= guards against a zero latency setting stalling forever
                if (wait_cnt_r <= 4'd1) state_nxt_s = CHECK;
                else                    state_nxt_s = WAIT;
            end
            CHECK: begin
`ifdef BIST_EARLY_ABORT_EN
                if (mismatch_s || last_vec_s) state_nxt_s = DONE;
                else                          state_nxt_s = APPLY;
`else
                if (last_vec_s) state_nxt_s = DONE;
                else            state_nxt_s = APPLY;
`endif
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Saturating failure count including the vector under check
    always_comb begin
        fail_cnt_nxt_s = fail_count;
        if (mismatch_s && (fail_count != 16'hFFFF)) begin
            fail_cnt_nxt_s = fail_count + 16'd1;
        end else begin
            fail_cnt_nxt_s = fail_count;
        end
    end

    // Operand drive, result bookkeeping and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 16'd0;
            first_fail_idx <= FAIL_NONE;
            {x1, x2, v, t, c} <= 40'd0;
            equation_flag  <= 1'b0;
            vec_idx_r      <= 16'd0;
            wait_cnt_r     <= 4'd0;
        end else begin
            case (state_r)
                LOAD: begin
                    fail_count     <= 16'd0;
                    vec_idx_r      <= 16'd0;
                    first_fail_idx <= FAIL_NONE;
                    pass           <= 1'b0;
                end
                APPLY: begin
                    {x1, x2, v, t, c} <= lfsr_q_s;
                    equation_flag     <= ~equation_flag;
                    wait_cnt_r        <= LAT_LOAD;
                end
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 4'd1;
                end
                CHECK: begin
                    if (mismatch_s) begin
                        fail_count <= fail_cnt_nxt_s;
                        if (first_fail_idx == FAIL_NONE) first_fail_idx <= vec_idx_r;
                    end
                    vec_idx_r <= vec_idx_r + 16'd1;
                    // pass is registered together with done so it is valid on the pulse
                    if (state_nxt_s == DONE) pass <= (fail_cnt_nxt_s == 16'd0);
                end
                default: begin
                end
            endcase
            busy <= (state_nxt_s == LOAD) || (state_nxt_s == APPLY) ||
                    (state_nxt_s == WAIT) || (state_nxt_s == CHECK);
            done <= (state_nxt_s == DONE);
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer: behavioural datapath with fault hooks plus an operand scoreboard.
module tb_bist_sequencer;
    import bist_pkg::*;

    localparam int          NV   = 64;
    localparam logic [39:0] SEED = 40'hA55AC33C96;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, equation_flag;
    logic [15:0] fail_count, first_fail_idx;
    logic [7:0]  x1, x2, v, t, c;
    logic [15:0] dut_a = 16'd0;
    logic [15:0] dut_b = 16'd0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          app_cnt = 0;
    int          cur_vec = 0;
    logic        flag_prev = 1'b0;
    bit          fault_b = 1'b0;
    bit          force_a0 = 1'b0;
    logic [39:0] exp_q[$];

    bist_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .x1(x1), .x2(x2), .v(v), .t(t), .c(c), .equation_flag(equation_flag),
        .dut_a(dut_a), .dut_b(dut_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] tb_step(input logic [39:0] s);
        return {s[38:0], s[39] ^ s[37] ^ s[20] ^ s[18]};
    endfunction

    // Datapath model, one cycle latency, with stuck-at hooks
    always @(posedge clk) begin
        dut_a <= force_a0 ? 16'd0 : golden_a(x1, x2);
        dut_b <= (fault_b && cur_vec >= 10) ? (golden_b(v, t, c) & 16'hFFF7) : golden_b(v, t, c);
    end

    // Scoreboard: every equation_flag toggle is one applied vector
    always @(negedge clk) begin
        if (rst_n && equation_flag !== flag_prev) begin
            cur_vec <= app_cnt;
            app_cnt <= app_cnt + 1;
            if (exp_q.size() > 0) chk("operands", {x1, x2, v, t, c}, exp_q.pop_front());
            else                  chk("spurious_apply", 40'(exp_q.size()), 40'd1);
        end else if (!busy) begin
            app_cnt <= 0;
        end
        flag_prev <= equation_flag;
        if (rst_n && done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic push_run(input int n);
        logic [39:0] s;
        exp_q.delete();
        s = SEED;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s);
            s = tb_step(s);
        end
    endtask

    task automatic fault_expect(output logic [15:0] cnt, output logic [15:0] first);
        logic [39:0] s;
        logic [15:0] gb;
        s = SEED; cnt = 16'd0; first = 16'hFFFF;
        for (int i = 0; i < NV; i++) begin
            gb = golden_b(s[23:16], s[15:8], s[7:0]);
            if (i >= 10 && gb[3]) begin
                cnt++;
                if (first == 16'hFFFF) first = 16'(i);
            end
            s = tb_step(s);
        end
    endtask

    task automatic launch(output int sc);
        @(posedge clk); #1 start = 1'b1; sc = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int sc, input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - sc;
                break;
            end
        end
    endtask

    initial begin
        int sc, lat, d0;
        logic [15:0] ec, ef;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail_count", fail_count, 16'd0);
        chk("rst_first_fail", first_fail_idx, 16'hFFFF);
        chk("rst_operands", {x1, x2, v, t, c}, 40'd0);
        chk("rst_eq_flag", equation_flag, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

`ifdef BIST_EARLY_ABORT_EN
        force_a0 = 1'b1;
        push_run(NV);
        launch(sc);
        wait_done(sc, 50, lat);
        chk("abort_latency", 40'(lat), 40'd5);
        chk("abort_pass", pass, 1'b0);
        chk("abort_fail_count", fail_count, 16'd1);
        chk("abort_first_fail", first_fail_idx, 16'd0);
        force_a0 = 1'b0;
`else
        // Golden run
        push_run(NV);
        launch(sc);
        wait_done(sc, 400, lat);
        chk("golden_latency", 40'(lat), 40'd194);
        chk("golden_pass", pass, 1'b1);
        chk("golden_fail_count", fail_count, 16'd0);
        chk("golden_first_fail", first_fail_idx, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("hold_pass", pass, 1'b1);
        chk("hold_busy", busy, 1'b0);
        chk("golden_queue_empty", 40'(exp_q.size()), 40'd0);

        // dut_b bit 3 stuck-at-0 from vector 10
        fault_expect(ec, ef);
        fault_b = 1'b1;
        push_run(NV);
        launch(sc);
        wait_done(sc, 400, lat);
        chk("fault_latency", 40'(lat), 40'd194);
        chk("fault_pass", pass, 1'b0);
        chk("fault_fail_count", fail_count, ec);
        chk("fault_first_fail", first_fail_idx, ef);
        fault_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_hold_count", fail_count, ec);

        // start pulses at vectors 5 and 40 must be ignored
        d0 = done_cnt;
        push_run(NV);
        launch(sc);
        repeat (16) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (104) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(sc, 400, lat);
        chk("midstart_latency", 40'(lat), 40'd194);
        chk("midstart_pass", pass, 1'b1);
        repeat (5) @(negedge clk);
        chk("midstart_done_count", 40'(done_cnt - d0), 40'd1);
        chk("midstart_idle", busy, 1'b0);

        // reset during WAIT of vector 20, then rerun from the seed
        d0 = done_cnt;
        push_run(NV);
        launch(sc);
        repeat (62) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_operands", {x1, x2, v, t, c}, 40'd0);
        chk("abort_pass", pass, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        push_run(NV);
        launch(sc);
        wait_done(sc, 400, lat);
        chk("rerun_latency", 40'(lat), 40'd194);
        chk("rerun_pass", pass, 1'b1);
        repeat (3) @(negedge clk);
        chk("rerun_done_count", 40'(done_cnt - d0), 40'd1);
        chk("rerun_queue_empty", 40'(exp_q.size()), 40'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
